// File: rtl/buzzer_pcm.sv
// buzzer_pcm: boxcar-decimates the 1-bit buzzer square wave, scaled by a
// 3-bit level, into signed 16-bit PCM samples. Samples are offered on a
// valid/ready handshake, and a sticky flag records any overwritten sample.
// Optional feature macro: BUZZER_PCM_SOFT_MUTE_EN. When it is defined, the
// effective level ramps one step per sample toward its target.
module buzzer_pcm #(
    parameter int unsigned DECIMATE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        buzzer,
    input  logic        enable,
    input  logic [2:0]  level,
    output logic [15:0] sample,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overrun
);

    localparam int unsigned SHIFT = $clog2(DECIMATE);
    localparam int unsigned ACC_W = 16 + SHIFT;

    logic [2:0]              target_lvl;
    logic [2:0]              lvl_eff;
    logic signed [ACC_W-1:0] mag;
    logic signed [ACC_W-1:0] contrib;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    boundary;
    logic                    load;
    logic                    xfer;
    logic [15:0]             sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    assign target_lvl = enable ? level : 3'd0;

`ifdef BUZZER_PCM_SOFT_MUTE_EN
    logic [2:0] lvl_q, lvl_d;

    assign lvl_eff = lvl_q;

    // Step the level once per sample so each period uses a constant amplitude.
    always_comb begin
        lvl_d = lvl_q;
        if (load) begin
            if (lvl_q < target_lvl) begin
                lvl_d = lvl_q + 3'd1;
            end else if (lvl_q > target_lvl) begin
                lvl_d = lvl_q - 3'd1;
            end
        end
    end

    // Effective level register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q <= 3'd0;
        end else begin
            lvl_q <= lvl_d;
        end
    end
`else
    assign lvl_eff = target_lvl;
`endif

    // Per-tick contribution: +/- (L << 12), zero-extended before negation.
    always_comb begin
        mag     = ACC_W'({lvl_eff, 12'd0});
        contrib = buzzer ? mag : -mag;
        sum     = acc_q + contrib;
    end

    // Tick counter exists only when more than one tick makes a sample.
    if (SHIFT > 0) begin : g_cnt
        logic [SHIFT-1:0] cnt_q, cnt_d;

        assign boundary = (cnt_q == SHIFT'(DECIMATE - 1));

        // Wrap the counter at the sample boundary.
        always_comb begin
            cnt_d = cnt_q;
            if (clk_en) begin
                cnt_d = boundary ? '0 : cnt_q + 1'b1;
            end
        end

        // Tick counter register.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end else begin : g_no_cnt
        assign boundary = 1'b1;
    end

    assign load = clk_en && boundary;
    assign xfer = valid_q && sample_ready;

    // Accumulate, emit on the boundary, and run the output handshake.
    always_comb begin
        acc_d     = acc_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (clk_en) begin
            acc_d = boundary ? '0 : sum;
        end
        if (load) begin
            // Arithmetic shift floors; the result always fits in 16 bits.
            sample_d = 16'(sum >>> SHIFT);
            valid_d  = 1'b1;
            if (valid_q && !sample_ready) begin
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            sample_q  <= 16'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_buzzer_pcm.sv
// Directed bench for buzzer_pcm with DECIMATE=4 and hand-computed samples.
// Honours BUZZER_PCM_SOFT_MUTE_EN to select the expected level behaviour.
module tb_buzzer_pcm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b0;
    logic        buzzer = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  level = 3'd0;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;

    buzzer_pcm #(
        .DECIMATE(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .buzzer       (buzzer),
        .enable       (enable),
        .level        (level),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // One clk_en tick with the given buzzer value; returns #1 after the edge.
    task automatic tick(input logic b);
        buzzer = b;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("reset_sample", sample, 16'h0000);
        check("reset_valid", 16'(sample_valid), 16'd0);
        check("reset_overrun", 16'(overrun), 16'd0);

`ifdef BUZZER_PCM_SOFT_MUTE_EN
        // Ramp from silence: period k uses level min(k,7).
        sample_ready = 1'b1;
        level        = 3'd7;
        enable       = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick(1'b1);
            tick(1'b1);
            tick(1'b1);
            tick(1'b1);
            check($sformatf("ramp_valid_%0d", k), 16'(sample_valid), 16'd1);
            check($sformatf("ramp_sample_%0d", k), sample,
                  16'((k < 7 ? k : 7) * 4096));
        end
`else
        // Full positive, valid exactly one cycle.
        sample_ready = 1'b1;
        enable       = 1'b1;
        level        = 3'd7;
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check("t1_valid_early", 16'(sample_valid), 16'd0);
        tick(1'b1);
        check("t1_sample", sample, 16'h7000);
        check("t1_valid", 16'(sample_valid), 16'd1);
        idle(1);
        check("t1_valid_drop", 16'(sample_valid), 16'd0);

        // Alternating buzzer cancels.
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        check("t2_sample", sample, 16'h0000);
        check("t2_valid", 16'(sample_valid), 16'd1);

        // level 3, buzzer low: -12288.
        level = 3'd3;
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        check("t3_sample", sample, 16'hD000);
        idle(1);

        // Ready rises on the same edge as the next load.
        sample_ready = 1'b0;
        level        = 3'd1;
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check("t5_first", sample, 16'h1000);
        level = 3'd2;
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        sample_ready = 1'b1;
        tick(1'b1);
        check("t5_sample", sample, 16'h2000);
        check("t5_valid", 16'(sample_valid), 16'd1);
        check("t5_overrun", 16'(overrun), 16'd0);
        idle(1);
        check("t5_valid_drop", 16'(sample_valid), 16'd0);

        // Overwrite while stalled sets sticky overrun.
        sample_ready = 1'b0;
        level        = 3'd1;
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check("t4_first_overrun", 16'(overrun), 16'd0);
        level = 3'd2;
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check("t4_sample", sample, 16'h2000);
        check("t4_valid", 16'(sample_valid), 16'd1);
        check("t4_overrun", 16'(overrun), 16'd1);
        sample_ready = 1'b1;
        idle(1);
        check("t4_valid_drop", 16'(sample_valid), 16'd0);
        check("t4_overrun_sticky", 16'(overrun), 16'd1);

        // Reset mid-accumulation discards the partial sum.
        level = 3'd7;
        tick(1'b0);
        tick(1'b0);
        do_reset();
        check("t6_overrun_clr", 16'(overrun), 16'd0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check("t6_valid_early", 16'(sample_valid), 16'd0);
        tick(1'b1);
        check("t6_valid", 16'(sample_valid), 16'd1);
        check("t6_sample", sample, 16'h7000);
        idle(1);

        // Buzzer changes between ticks are ignored.
        tick(1'b1);
        buzzer = 1'b0;
        idle(2);
        tick(1'b1);
        buzzer = 1'b0;
        idle(1);
        tick(1'b1);
        tick(1'b1);
        check("t7_between", sample, 16'h7000);
        idle(1);

        // level 0 still emits samples.
        level = 3'd0;
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check("t8_valid", 16'(sample_valid), 16'd1);
        check("t8_sample", sample, 16'h0000);
        idle(1);

        // Enable low silences; then the first enabled sample is full scale.
        level  = 3'd7;
        enable = 1'b0;
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        check("t9_silent", sample, 16'h0000);
        idle(1);
        enable = 1'b1;
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check("t9_enabled", sample, 16'h7000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
